// File: rtl/psx_poll_sched.sv
// rtl/psx_poll_sched.sv - two-port PSX controller polling scheduler over a shared byte engine (optional PSX_ANALOG_EN)
module psx_poll_sched #(
    parameter int POLL_PERIOD = 116,
    parameter int ATT_SETUP   = 2,
    parameter int ATT_HOLD    = 2,
    parameter int PORT_GAP    = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    output logic        att0_n,
    output logic        att1_n,
    output logic        xfer_start,
    output logic [7:0]  xfer_tx,
    input  logic        xfer_done,
    input  logic [7:0]  xfer_rx,
    input  logic        xfer_acked,
    output logic [15:0] btn0,
    output logic [15:0] btn1,
    output logic [1:0]  present,
    output logic [1:0]  upd
`ifdef PSX_ANALOG_EN
    ,
    output logic [31:0] stick0,
    output logic [31:0] stick1
`endif
);

`ifdef PSX_ANALOG_EN
    localparam int IDX_W = 4;
`else
    localparam int IDX_W = 3;
`endif
    localparam int PER_W = $clog2(POLL_PERIOD + 1);
    localparam int DLY_W = 8;
    localparam logic [DLY_W-1:0] SETUP_LAST = DLY_W'(ATT_SETUP - 1);
    // CHECK counts as the first hold cycle, so HOLD itself lasts ATT_HOLD-1 cycles
    localparam logic [DLY_W-1:0] HOLD_LAST  = DLY_W'((ATT_HOLD > 1) ? ATT_HOLD - 2 : 0);
    localparam logic [DLY_W-1:0] GAP_LAST   = DLY_W'(PORT_GAP - 1);
    localparam logic [IDX_W-1:0] IDX_DIG_LAST = IDX_W'(5);

    typedef enum logic [2:0] {S_IDLE, S_SETUP, S_SEND, S_WAIT, S_CHECK, S_HOLD, S_GAP} state_t;

    state_t             state;
    state_t             next_state;
    logic [DLY_W-1:0]   dly_cnt;
    logic [PER_W-1:0]   period_cnt;
    logic               period_pend;
    logic               port;
    logic [IDX_W-1:0]   byte_idx;
    logic [IDX_W-1:0]   last_idx;
    logic [7:0]         rx_q;
    logic               ack_q;
    logic               fail_q;
    logic               byte_err;
    logic [7:0]         btn_lo;
    logic [7:0]         btn_hi;
    logic               start_round;
    logic               commit;

`ifdef PSX_ANALOG_EN
    logic               ana_q;
    logic [31:0]        stick_sh;
    assign last_idx = ana_q ? IDX_W'(9) : IDX_DIG_LAST;
`else
    assign last_idx = IDX_DIG_LAST;
`endif

    assign start_round = (state == S_IDLE) && (next_state == S_SETUP);
    assign commit      = (state == S_HOLD) && (next_state != S_HOLD);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= next_state;
    end

    // Next-state logic
    always_comb begin
        next_state = state;
        case (state)
            S_IDLE:  if (en && period_pend) next_state = S_SETUP;
            S_SETUP: if (dly_cnt == SETUP_LAST) next_state = S_SEND;
            S_SEND:  next_state = S_WAIT;
            S_WAIT:  if (xfer_done) next_state = S_CHECK;
            S_CHECK: next_state = (byte_err || byte_idx == last_idx) ? S_HOLD : S_SEND;
            S_HOLD:  if (dly_cnt == HOLD_LAST) next_state = (!port && en) ? S_GAP : S_IDLE;
            S_GAP:   if (dly_cnt == GAP_LAST) next_state = S_SETUP;
            default: next_state = S_IDLE;
        endcase
    end

    // Outputs decoded from state: att low for the whole transaction of the active port
    always_comb begin
        att0_n     = 1'b1;
        att1_n     = 1'b1;
        xfer_start = 1'b0;
        xfer_tx    = 8'h00;
        if (state != S_IDLE && state != S_GAP) begin
            if (port) att1_n = 1'b0;
            else      att0_n = 1'b0;
        end
        if (state == S_SEND) xfer_start = 1'b1;
        if (state == S_SEND || state == S_WAIT) begin
            if (byte_idx == IDX_W'(1))      xfer_tx = 8'h01;
            else if (byte_idx == IDX_W'(2)) xfer_tx = 8'h42;
        end
    end

    // Validation of the byte just received; ack is required on every byte but the last
    always_comb begin
        byte_err = 1'b0;
        if (byte_idx != last_idx && !ack_q) byte_err = 1'b1;
        if (byte_idx == IDX_W'(2) && rx_q[7:4] != 4'h4 && rx_q[7:4] != 4'h7) byte_err = 1'b1;
        if (byte_idx == IDX_W'(3) && rx_q != 8'h5A) byte_err = 1'b1;
    end

    // Delay counter for SETUP / HOLD / GAP, restarts on every state change
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                   dly_cnt <= '0;
        else if (state != next_state) dly_cnt <= '0;
        else if (state == S_SETUP || state == S_HOLD || state == S_GAP) dly_cnt <= dly_cnt + 1'b1;
    end

    // Period timer: reloads at round start, raises a single pending expiry
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            period_cnt  <= '0;
            period_pend <= 1'b1;
        end else if (start_round) begin
            period_cnt  <= PER_W'(POLL_PERIOD - 1);
            period_pend <= 1'b0;
        end else if (period_cnt != '0) begin
            period_cnt <= period_cnt - 1'b1;
            if (period_cnt == PER_W'(1)) period_pend <= 1'b1;
        end
    end

    // Transaction datapath: port select, byte index, reply capture and staging
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            port     <= 1'b0;
            byte_idx <= IDX_W'(1);
            rx_q     <= 8'h00;
            ack_q    <= 1'b0;
            fail_q   <= 1'b0;
            btn_lo   <= 8'hFF;
            btn_hi   <= 8'hFF;
        end else begin
            if (start_round)                                  port <= 1'b0;
            else if (state == S_GAP && next_state == S_SETUP) port <= 1'b1;
            if (state == S_SETUP) begin
                byte_idx <= IDX_W'(1);
                fail_q   <= 1'b0;
            end
            if (state == S_WAIT && xfer_done) begin
                rx_q  <= xfer_rx;
                ack_q <= xfer_acked;
            end
            if (state == S_CHECK) begin
                fail_q <= byte_err;
                if (next_state == S_SEND)  byte_idx <= byte_idx + 1'b1;
                if (byte_idx == IDX_W'(4)) btn_lo <= rx_q;
                if (byte_idx == IDX_W'(5)) btn_hi <= rx_q;
            end
        end
    end

`ifdef PSX_ANALOG_EN
    // Analog mode flag from the ID byte and stick bytes 6..9 shifted in LSB-first
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ana_q    <= 1'b0;
            stick_sh <= 32'h80808080;
        end else begin
            if (state == S_SETUP) ana_q <= 1'b0;
            if (state == S_CHECK && byte_idx == IDX_W'(2)) ana_q <= (rx_q[7:4] == 4'h7);
            if (state == S_CHECK && byte_idx >= IDX_W'(6)) stick_sh <= {rx_q, stick_sh[31:8]};
        end
    end

    // Stick outputs committed together with the button word
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stick0 <= 32'h80808080;
            stick1 <= 32'h80808080;
        end else if (commit) begin
            if (port) stick1 <= (fail_q || !ana_q) ? 32'h80808080 : stick_sh;
            else      stick0 <= (fail_q || !ana_q) ? 32'h80808080 : stick_sh;
        end
    end
`endif

    // Published results change in the cycle att is released
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            btn0    <= 16'hFFFF;
            btn1    <= 16'hFFFF;
            present <= 2'b00;
            upd     <= 2'b00;
        end else begin
            upd <= 2'b00;
            if (commit) begin
                upd <= port ? 2'b10 : 2'b01;
                if (port) begin
                    btn1       <= fail_q ? 16'hFFFF : {btn_hi, btn_lo};
                    present[1] <= !fail_q;
                end else begin
                    btn0       <= fail_q ? 16'hFFFF : {btn_hi, btn_lo};
                    present[0] <= !fail_q;
                end
            end
        end
    end

endmodule

// File: tb/tb_psx_poll_sched.sv
// tb/tb_psx_poll_sched.sv - self-checking bench for psx_poll_sched
`timescale 1ns/1ps
module tb_psx_poll_sched;

    localparam int POLL_PERIOD = 116;
    localparam int ATT_SETUP   = 2;
    localparam int ATT_HOLD    = 2;
    localparam int PORT_GAP    = 4;
    localparam int ENG_LAT     = 3;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        en = 1'b0;
    logic        att0_n, att1_n, xfer_start;
    logic [7:0]  xfer_tx;
    logic        xfer_done = 1'b0;
    logic [7:0]  xfer_rx = 8'h00;
    logic        xfer_acked = 1'b0;
    logic [15:0] btn0, btn1;
    logic [1:0]  present, upd;
`ifdef PSX_ANALOG_EN
    logic [31:0] stick0, stick1;
`endif

    psx_poll_sched #(
        .POLL_PERIOD(POLL_PERIOD), .ATT_SETUP(ATT_SETUP),
        .ATT_HOLD(ATT_HOLD), .PORT_GAP(PORT_GAP)
    ) dut (
        .clk(clk), .rst_n(rst_n), .en(en),
        .att0_n(att0_n), .att1_n(att1_n),
        .xfer_start(xfer_start), .xfer_tx(xfer_tx),
        .xfer_done(xfer_done), .xfer_rx(xfer_rx), .xfer_acked(xfer_acked),
        .btn0(btn0), .btn1(btn1), .present(present), .upd(upd)
`ifdef PSX_ANALOG_EN
        , .stick0(stick0), .stick1(stick1)
`endif
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        p;
        logic [15:0] btn;
        logic        pres;
        logic [31:0] stick;
    } exp_t;

    exp_t        sb[$];
    logic [7:0]  rep [0:1][0:8];
    logic [8:0]  ack_mask [0:1];
    int          n_chk = 0;
    int          n_pass = 0;
    int          cyc = 0;
    int          eng_idx = 0, eng_byte = 0, eng_cnt = 0;
    logic        eng_busy = 1'b0, eng_port = 1'b0;
    logic        att0_q = 1'b1, att1_q = 1'b1;
    int          low_cnt = 0, setup_meas = -1, st_cnt = 0;
    logic        started = 1'b0;
    int          starts_last [0:1];
    logic        gap_run = 1'b0, hold_run = 1'b0;
    int          gap_cnt = 0, gap_meas = -1, hold_cnt = 0, hold_meas = -1;
    logic        both_low = 1'b0, att1_seen = 1'b0;
    int          round_start = 0, round_start_prev = 0, n_rounds = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic step();
        @(negedge clk);
        #2;
    endtask

    task automatic push(input logic p, input logic [15:0] b, input logic pr, input logic [31:0] s);
        exp_t e;
        e.p = p; e.btn = b; e.pres = pr; e.stick = s;
        sb.push_back(e);
    endtask

    task automatic set_port(input int p, input logic [7:0] b1, input logic [7:0] b2, input logic [7:0] b3,
                            input logic [7:0] b4, input logic [7:0] b5, input logic [8:0] mask);
        rep[p][0] = b1; rep[p][1] = b2; rep[p][2] = b3; rep[p][3] = b4; rep[p][4] = b5;
        for (int i = 5; i < 9; i++) rep[p][i] = 8'h00;
        ack_mask[p] = mask;
    endtask

    task automatic wait_sb(input string tag, input int limit);
        int n = 0;
        while (sb.size() != 0 && n < limit) begin
            step();
            n++;
        end
        chk(tag, 32'(sb.size() != 0), 32'd0);
    endtask

    task automatic wait_idx(input string tag, input int target, input int limit);
        int n = 0;
        while (eng_idx != target && n < limit) begin
            step();
            n++;
        end
        chk(tag, 32'(eng_idx != target), 32'd0);
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Serial engine model, timing monitors and scoreboard comparison
    always @(negedge clk) begin
        if (!rst_n) begin
            xfer_done = 1'b0; xfer_rx = 8'h00; xfer_acked = 1'b0;
            eng_busy = 1'b0; eng_idx = 0; low_cnt = 0; started = 1'b0;
            hold_run = 1'b0; gap_run = 1'b0; st_cnt = 0;
            att0_q = 1'b1; att1_q = 1'b1;
        end else begin
            if (!att0_n && !att1_n) both_low = 1'b1;
            if (!att1_n) att1_seen = 1'b1;
            if (att0_q && att1_q && !att0_n) begin
                round_start_prev = round_start;
                round_start = cyc;
                n_rounds++;
            end
            if (!att0_n || !att1_n) begin
                if (!started) begin
                    if (xfer_start) begin
                        setup_meas = low_cnt;
                        started = 1'b1;
                    end else low_cnt++;
                end
                if (xfer_start) st_cnt++;
            end else begin
                low_cnt = 0;
                started = 1'b0;
            end
            if (!att0_q && att0_n) begin
                starts_last[0] = st_cnt; st_cnt = 0; gap_run = 1'b1; gap_cnt = 1;
            end else if (gap_run) begin
                if (!att1_n) begin
                    gap_meas = gap_cnt; gap_run = 1'b0;
                end else gap_cnt++;
            end
            if (!att1_q && att1_n) begin
                starts_last[1] = st_cnt; st_cnt = 0;
            end
            if (hold_run) begin
                if (!att0_n || !att1_n) hold_cnt++;
                else begin
                    hold_meas = hold_cnt; hold_run = 1'b0;
                end
            end
            for (int p = 0; p < 2; p++) begin
                if (upd[p]) begin
                    if (sb.size() == 0) chk("upd_unexpected", 32'(p), 32'hFFFF_FFFF);
                    else begin
                        exp_t e;
                        e = sb.pop_front();
                        chk("upd_port", 32'(p), 32'(e.p));
                        chk(p ? "btn1" : "btn0", 32'(p ? btn1 : btn0), 32'(e.btn));
                        chk("present_bit", 32'(present[p]), 32'(e.pres));
                        chk("att_rise_with_upd", 32'(p ? {att1_q, att1_n} : {att0_q, att0_n}), 32'd1);
`ifdef PSX_ANALOG_EN
                        chk(p ? "stick1" : "stick0", p ? stick1 : stick0, e.stick);
`endif
                    end
                end
            end
            xfer_done = 1'b0;
            if (eng_busy) begin
                eng_cnt--;
                if (eng_cnt == 0) begin
                    xfer_done  = 1'b1;
                    xfer_rx    = rep[eng_port][eng_byte];
                    xfer_acked = ack_mask[eng_port][eng_byte];
                    eng_busy   = 1'b0;
                    hold_run   = 1'b1;
                    hold_cnt   = 0;
                end
            end
            if (xfer_start) begin
                chk("xfer_tx", 32'(xfer_tx), (eng_idx == 0) ? 32'h01 : (eng_idx == 1) ? 32'h42 : 32'h00);
                eng_byte = eng_idx;
                eng_idx++;
                eng_busy = 1'b1;
                eng_cnt  = ENG_LAT;
                eng_port = !att1_n;
            end
            if (att0_n && att1_n) eng_idx = 0;
            att0_q = att0_n;
            att1_q = att1_n;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_chk);
        $fatal(1, "watchdog");
    end

    initial begin
        int c0, r0;
        starts_last[0] = -1;
        starts_last[1] = -1;
        for (int p = 0; p < 2; p++) set_port(p, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 9'h000);
        repeat (3) step();
        chk("rst_att0_n", 32'(att0_n), 32'd1);
        chk("rst_att1_n", 32'(att1_n), 32'd1);
        chk("rst_xfer_start", 32'(xfer_start), 32'd0);
        chk("rst_xfer_tx", 32'(xfer_tx), 32'h00);
        chk("rst_btn0", 32'(btn0), 32'hFFFF);
        chk("rst_btn1", 32'(btn1), 32'hFFFF);
        chk("rst_present", 32'(present), 32'd0);
        chk("rst_upd", 32'(upd), 32'd0);

        // Round 1: digital pad on port 0 (no ack after byte 5), silent port 1
        set_port(0, 8'hFF, 8'h41, 8'h5A, 8'hFE, 8'h7F, 9'h00F);
        set_port(1, 8'hFF, 8'h41, 8'h5A, 8'h00, 8'h00, 9'h000);
        push(1'b0, 16'h7FFE, 1'b1, 32'h80808080);
        push(1'b1, 16'hFFFF, 1'b0, 32'h80808080);
        en = 1'b1;
        rst_n = 1'b1;
        step();
        chk("first_round_immediate", 32'(att0_n), 32'd0);
        wait_sb("round1_timeout", 400);
        chk("r1_present", 32'(present), 32'b01);
        chk("r1_starts_p0", 32'(starts_last[0]), 32'd5);
        chk("r1_starts_p1", 32'(starts_last[1]), 32'd1);
        chk("r1_setup_cycles", 32'(setup_meas), 32'(ATT_SETUP));
        chk("r1_gap_cycles", 32'(gap_meas), 32'(PORT_GAP));
        chk("r1_hold_after_abort", 32'(hold_meas), 32'(ATT_HOLD));
        chk("r1_att_exclusive", 32'(both_low), 32'd0);

        // Round 2: bad sync byte on port 0, good pad on port 1
        set_port(0, 8'hFF, 8'h41, 8'h00, 8'hFE, 8'h7F, 9'h1FF);
`ifdef PSX_ANALOG_EN
        set_port(1, 8'hFF, 8'h41, 8'h5A, 8'h34, 8'h12, 9'h00F);
`else
        set_port(1, 8'hFF, 8'h73, 8'h5A, 8'h34, 8'h12, 9'h00F);
`endif
        push(1'b0, 16'hFFFF, 1'b0, 32'h80808080);
        push(1'b1, 16'h1234, 1'b1, 32'h80808080);
        wait_sb("round2_timeout", 400);
        chk("r2_starts_p0", 32'(starts_last[0]), 32'd3);
        chk("r2_starts_p1", 32'(starts_last[1]), 32'd5);
        chk("r2_period", 32'(round_start - round_start_prev), 32'(POLL_PERIOD));
        chk("r2_present", 32'(present), 32'b10);
        chk("r2_hold_cycles", 32'(hold_meas), 32'(ATT_HOLD));

        // Round 3: drop en during port 0 byte 3
        set_port(0, 8'hFF, 8'h41, 8'h5A, 8'hAA, 8'h55, 9'h00F);
        set_port(1, 8'hFF, 8'h41, 8'h5A, 8'h11, 8'h22, 9'h00F);
        push(1'b0, 16'h55AA, 1'b1, 32'h80808080);
        wait_idx("r3_byte3_timeout", 3, 300);
        en = 1'b0;
        att1_seen = 1'b0;
        r0 = n_rounds;
        wait_sb("round3_timeout", 100);
        repeat (150) step();
        chk("r3_port1_not_polled", 32'(att1_seen), 32'd0);
        chk("r3_no_new_round", 32'(n_rounds), 32'(r0));
        chk("r3_present", 32'(present), 32'b11);
        chk("r3_starts_p0", 32'(starts_last[0]), 32'd5);
        push(1'b0, 16'h55AA, 1'b1, 32'h80808080);
        push(1'b1, 16'h2211, 1'b1, 32'h80808080);
        en = 1'b1;
        c0 = cyc;
        step();
        chk("r3_restart_att0", 32'(att0_n), 32'd0);
        chk("r3_restart_delay", 32'(round_start - c0), 32'd1);
        wait_sb("round3b_timeout", 400);
        chk("r3b_btn1", 32'(btn1), 32'h2211);

        // Round 4: asynchronous reset while waiting for byte 1
        wait_idx("r4_start_timeout", 1, 300);
        step();
        rst_n = 1'b0;
        #1;
        chk("arst_att0_n", 32'(att0_n), 32'd1);
        chk("arst_att1_n", 32'(att1_n), 32'd1);
        chk("arst_xfer_start", 32'(xfer_start), 32'd0);
        chk("arst_xfer_tx", 32'(xfer_tx), 32'h00);
        chk("arst_btn0", 32'(btn0), 32'hFFFF);
        chk("arst_btn1", 32'(btn1), 32'hFFFF);
        chk("arst_present", 32'(present), 32'd0);
        chk("arst_upd", 32'(upd), 32'd0);
        sb.delete();
        repeat (2) step();
        push(1'b0, 16'h55AA, 1'b1, 32'h80808080);
        push(1'b1, 16'h2211, 1'b1, 32'h80808080);
        rst_n = 1'b1;
        step();
        chk("arst_round_immediate", 32'(att0_n), 32'd0);
        wait_sb("round4_timeout", 400);
        chk("r4_present", 32'(present), 32'b11);

`ifdef PSX_ANALOG_EN
        // Analog pad on port 0, digital on port 1
        set_port(0, 8'hFF, 8'h73, 8'h5A, 8'hFF, 8'hFF, 9'h0FF);
        rep[0][5] = 8'h10; rep[0][6] = 8'h20; rep[0][7] = 8'h30; rep[0][8] = 8'h40;
        set_port(1, 8'hFF, 8'h41, 8'h5A, 8'h00, 8'h00, 9'h00F);
        push(1'b0, 16'hFFFF, 1'b1, 32'h40302010);
        push(1'b1, 16'h0000, 1'b1, 32'h80808080);
        wait_sb("analog_timeout", 400);
        chk("ana_starts_p0", 32'(starts_last[0]), 32'd9);
        chk("ana_stick0", stick0, 32'h40302010);
`endif

        chk("att_exclusive_all", 32'(both_low), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
